// File: rtl/firebird7_in_gate1_tessent_data_mux_pkg.sv
// Shared types and default sizing for the IJTAG / functional data mux.
// Optional parity output is enabled by FIREBIRD7_TESSENT_DATA_MUX_PARITY_EN (see top).
package firebird7_in_gate1_tessent_data_mux_pkg;

  localparam int DEF_WIDTH       = 19;
  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_HOLD_CYCLES = 2;
  // Wide enough for HOLD_CYCLES-1 up to 14.
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    FUNC  = 2'd0,
    HOLD  = 2'd1,
    IJTAG = 2'd2
  } state_t;

endpackage

// File: rtl/firebird7_in_gate1_tessent_data_mux_hold_ctr.sv
// Break-before-make hold counter: loadable, decrements to zero and stops there.
module firebird7_in_gate1_tessent_data_mux_hold_ctr
  import firebird7_in_gate1_tessent_data_mux_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_mch.sv
// Glitch-free functional/IJTAG data mux with break-before-make HOLD between sources.
// Define FIREBIRD7_TESSENT_DATA_MUX_PARITY_EN to add the registered data_out_par output.
module firebird7_in_gate1_tessent_data_mux_mch
  import firebird7_in_gate1_tessent_data_mux_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic                       ijtag_tck,
  input  logic                       ijtag_reset,
  input  logic                       ijtag_sel_req,
  input  logic [$clog2(NUM_CH)-1:0]  ijtag_sel_ch,
  input  logic [WIDTH-1:0]           functional_data_in,
  input  logic [NUM_CH*WIDTH-1:0]    ijtag_data_in,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(NUM_CH)-1:0]  active_ch,
  output logic                       ijtag_active,
  output logic                       switch_busy,
`ifdef FIREBIRD7_TESSENT_DATA_MUX_PARITY_EN
  output logic                       data_out_par,
  output logic                       sel_err
`else
  output logic                       sel_err
`endif
);

  localparam int               CH_W      = $clog2(NUM_CH);
  localparam logic [CH_W:0]    NUM_CH_V  = (CH_W+1)'(NUM_CH);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t            state, state_nxt;
  logic              lat_ij, lat_ij_nxt;
  logic [CH_W-1:0]   lat_ch, lat_ch_nxt;
  logic              cur_ij, tgt_ij;
  logic [CH_W-1:0]   cur_ch, tgt_ch;
  logic              ch_ok, change;
  logic              ctr_load, ctr_dec, ctr_zero, leave_hold;
  logic [WIDTH-1:0]  ch_data, d_nxt;

  // While in HOLD the "current source" is the pending target, so a request
  // matching it is not a change and does not restart the hold.
  always_comb begin
    cur_ij = (state == HOLD) ? lat_ij : ijtag_active;
    cur_ch = (state == HOLD) ? lat_ch : active_ch;
    ch_ok  = ({1'b0, ijtag_sel_ch} < NUM_CH_V);
    tgt_ij = cur_ij;
    tgt_ch = cur_ch;
    if (!ijtag_sel_req) begin
      tgt_ij = 1'b0;
      tgt_ch = '0;
    end else if (ch_ok) begin
      tgt_ij = 1'b1;
      tgt_ch = ijtag_sel_ch;
    end
    change = (tgt_ij != cur_ij) || (tgt_ch != cur_ch);
  end

  always_comb begin
    state_nxt  = state;
    lat_ij_nxt = lat_ij;
    lat_ch_nxt = lat_ch;
    ctr_load   = 1'b0;
    ctr_dec    = 1'b0;
    leave_hold = 1'b0;
    case (state)
      FUNC, IJTAG: begin
        if (change) begin
          state_nxt  = HOLD;
          lat_ij_nxt = tgt_ij;
          lat_ch_nxt = tgt_ch;
          ctr_load   = 1'b1;
        end
      end
      HOLD: begin
        if (change) begin
          lat_ij_nxt = tgt_ij;
          lat_ch_nxt = tgt_ch;
          ctr_load   = 1'b1;
        end else if (ctr_zero) begin
          state_nxt  = lat_ij ? IJTAG : FUNC;
          leave_hold = 1'b1;
        end else begin
          ctr_dec    = 1'b1;
        end
      end
      default: state_nxt = FUNC;
    endcase
  end

  always_comb begin
    ch_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (active_ch == CH_W'(k)) ch_data = ijtag_data_in[k*WIDTH +: WIDTH];
    end
    d_nxt = data_out;
    case (state)
      FUNC:    d_nxt = functional_data_in;
      IJTAG:   d_nxt = ch_data;
      default: d_nxt = data_out;
    endcase
  end

  firebird7_in_gate1_tessent_data_mux_hold_ctr u_hold_ctr (
    .clk      (ijtag_tck),
    .rst_n    (ijtag_reset),
    .load     (ctr_load),
    .dec      (ctr_dec),
    .load_val (HOLD_LOAD),
    .zero     (ctr_zero)
  );

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      state        <= FUNC;
      lat_ij       <= 1'b0;
      lat_ch       <= '0;
      active_ch    <= '0;
      ijtag_active <= 1'b0;
      sel_err      <= 1'b0;
      data_out     <= '0;
    end else begin
      state    <= state_nxt;
      lat_ij   <= lat_ij_nxt;
      lat_ch   <= lat_ch_nxt;
      data_out <= d_nxt;
      if (leave_hold) begin
        active_ch    <= lat_ch;
        ijtag_active <= lat_ij;
      end
      if (ijtag_sel_req && !ch_ok) sel_err <= 1'b1;
    end
  end

  assign switch_busy = (state == HOLD);

`ifdef FIREBIRD7_TESSENT_DATA_MUX_PARITY_EN
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) data_out_par <= 1'b0;
    else              data_out_par <= ^d_nxt;
  end
`endif

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_mch.sv
// Scoreboard bench for the functional/IJTAG data mux (default sizing plus a NUM_CH=5 instance).
module tb_firebird7_in_gate1_tessent_data_mux_mch;

  localparam int W   = 19;
  localparam int NCH = 4;
  localparam int HC  = 2;

  logic            tck = 1'b0;
  logic            rst_n;
  logic            sel_req;
  logic [1:0]      sel_ch;
  logic [W-1:0]    func_d;
  logic [NCH*W-1:0] ij_d;
  logic [W-1:0]    dout;
  logic [1:0]      act_ch;
  logic            ij_act, busy, err, par;

  logic            req5;
  logic [2:0]      ch5;
  logic [W-1:0]    func5;
  logic [5*W-1:0]  ij5;
  logic [W-1:0]    dout5;
  logic [2:0]      act5;
  logic            ij_act5, busy5, err5, par5;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 tck = ~tck;

  firebird7_in_gate1_tessent_data_mux_mch dut (
    .ijtag_tck          (tck),
    .ijtag_reset        (rst_n),
    .ijtag_sel_req      (sel_req),
    .ijtag_sel_ch       (sel_ch),
    .functional_data_in (func_d),
    .ijtag_data_in      (ij_d),
    .data_out           (dout),
    .active_ch          (act_ch),
    .ijtag_active       (ij_act),
    .switch_busy        (busy),
`ifdef FIREBIRD7_TESSENT_DATA_MUX_PARITY_EN
    .data_out_par       (par),
`endif
    .sel_err            (err)
  );

  firebird7_in_gate1_tessent_data_mux_mch #(.NUM_CH(5)) dut5 (
    .ijtag_tck          (tck),
    .ijtag_reset        (rst_n),
    .ijtag_sel_req      (req5),
    .ijtag_sel_ch       (ch5),
    .functional_data_in (func5),
    .ijtag_data_in      (ij5),
    .data_out           (dout5),
    .active_ch          (act5),
    .ijtag_active       (ij_act5),
    .switch_busy        (busy5),
`ifdef FIREBIRD7_TESSENT_DATA_MUX_PARITY_EN
    .data_out_par       (par5),
`endif
    .sel_err            (err5)
  );

`ifndef FIREBIRD7_TESSENT_DATA_MUX_PARITY_EN
  assign par  = 1'b0;
  assign par5 = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] dout;
    logic [1:0]   ch;
    logic         ij;
    logic         busy;
    logic         err;
    logic         par;
  } exp_t;

  exp_t sbq[$];

  // Reference model: 0 = FUNC, 1 = HOLD, 2 = IJTAG; m_left counts remaining hold edges.
  int           m_state, m_src_ij, m_src_ch, m_tgt_ij, m_tgt_ch, m_left;
  logic [W-1:0] m_dout;
  logic         m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_src_ij = 0; m_src_ch = 0; m_tgt_ij = 0; m_tgt_ch = 0;
    m_left = 0; m_dout = '0; m_err = 1'b0;
    sbq.delete();
  endtask

  task automatic model_step();
    int cur_ij, cur_ch, t_ij, t_ch;
    exp_t e;
    cur_ij = (m_state == 1) ? m_tgt_ij : m_src_ij;
    cur_ch = (m_state == 1) ? m_tgt_ch : m_src_ch;
    t_ij = cur_ij;
    t_ch = cur_ch;
    if (!sel_req) begin
      t_ij = 0; t_ch = 0;
    end else if (int'(sel_ch) < NCH) begin
      t_ij = 1; t_ch = int'(sel_ch);
    end else begin
      m_err = 1'b1;
    end
    if (m_state == 0)      m_dout = func_d;
    else if (m_state == 2) m_dout = ij_d[m_src_ch*W +: W];
    if (m_state != 1) begin
      if (t_ij != cur_ij || t_ch != cur_ch) begin
        m_state = 1; m_tgt_ij = t_ij; m_tgt_ch = t_ch; m_left = HC;
      end
    end else if (t_ij != m_tgt_ij || t_ch != m_tgt_ch) begin
      m_tgt_ij = t_ij; m_tgt_ch = t_ch; m_left = HC;
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_state  = m_tgt_ij ? 2 : 0;
        m_src_ij = m_tgt_ij;
        m_src_ch = m_tgt_ch;
      end
    end
    e.dout = m_dout;
    e.ch   = 2'(m_src_ch);
    e.ij   = (m_src_ij != 0);
    e.busy = (m_state == 1);
    e.err  = m_err;
`ifdef FIREBIRD7_TESSENT_DATA_MUX_PARITY_EN
    e.par  = ^m_dout;
`else
    e.par  = 1'b0;
`endif
    sbq.push_back(e);
  endtask

  // Called just after a falling edge; applies inputs, clocks once, checks on the next falling edge.
  task automatic step(input logic req, input logic [1:0] ch, input logic [W-1:0] fd);
    exp_t e;
    sel_req = req;
    sel_ch  = ch;
    func_d  = fd;
    model_step();
    @(posedge tck);
    @(negedge tck);
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk("data_out", 32'(dout), 32'(e.dout));
      chk("active_ch", 32'(act_ch), 32'(e.ch));
      chk("ijtag_active", 32'(ij_act), 32'(e.ij));
      chk("switch_busy", 32'(busy), 32'(e.busy));
      chk("sel_err", 32'(err), 32'(e.err));
      chk("data_out_par", 32'(par), 32'(e.par));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dout"}, 32'(dout), 32'd0);
    chk({tag, "_ch"}, 32'(act_ch), 32'd0);
    chk({tag, "_ij"}, 32'(ij_act), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_par"}, 32'(par), 32'd0);
  endtask

  task automatic rand_ij();
    for (int k = 0; k < NCH; k++) ij_d[k*W +: W] = W'($urandom());
  endtask

  initial begin
    logic       r_req;
    logic [1:0] r_ch;
    rst_n = 1'b0; sel_req = 1'b0; sel_ch = '0; func_d = '0; ij_d = '0;
    req5 = 1'b0; ch5 = '0; func5 = '0; ij5 = '0;
    model_reset();
    #2;
    chk_all_zero("reset");
    repeat (2) @(negedge tck);
    rst_n = 1'b1;

    // Functional pass-through after reset.
    step(1'b0, 2'd0, 19'h1234A);
    chk("func_first", 32'(dout), 32'h1234A);

    // Switch to channel 2: two HOLD cycles, then IJTAG, then channel data.
    ij_d = '0;
    ij_d[2*W +: W] = 19'h7FFFF;
    ij_d[1*W +: W] = 19'h00555;
    step(1'b1, 2'd2, 19'h1234A);
    chk("hold_c1_busy", 32'(busy), 32'd1);
    step(1'b1, 2'd2, 19'h0AAAA);
    chk("hold_c2_busy", 32'(busy), 32'd1);
    chk("hold_c2_dout", 32'(dout), 32'h1234A);
    step(1'b1, 2'd2, 19'h0AAAA);
    chk("ij_enter_act", 32'(ij_act), 32'd1);
    chk("ij_enter_ch", 32'(act_ch), 32'd2);
    step(1'b1, 2'd2, 19'h0AAAA);
    chk("ij_data", 32'(dout), 32'h7FFFF);

    // Back to functional, then parity-interesting value.
    step(1'b0, 2'd0, 19'h00007);
    step(1'b0, 2'd0, 19'h00007);
    step(1'b0, 2'd0, 19'h00007);
    step(1'b0, 2'd0, 19'h00007);

    // Retarget during HOLD: ch2 then ch3 after one cycle.
    ij_d[3*W +: W] = 19'h3C3C3;
    step(1'b1, 2'd2, 19'h11111);
    step(1'b1, 2'd3, 19'h11111);
    step(1'b1, 2'd3, 19'h11111);
    chk("retarget_still_busy", 32'(busy), 32'd1);
    step(1'b1, 2'd3, 19'h11111);
    chk("retarget_ch", 32'(act_ch), 32'd3);
    step(1'b1, 2'd3, 19'h11111);
    chk("retarget_data", 32'(dout), 32'h3C3C3);

    // Randomised traffic, requests held for a few cycles at a time.
    r_req = 1'b1; r_ch = 2'd3;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        r_req = 1'($urandom_range(0, 1));
        r_ch  = 2'($urandom_range(0, 3));
      end
      rand_ij();
      step(r_req, r_ch, W'($urandom()));
    end

    // Reset in the middle of a HOLD.
    step(1'b1, 2'd1, 19'h22222);
    step(1'b0, 2'd0, 19'h22222);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midhold_reset");
    @(negedge tck);
    rst_n = 1'b1;
    model_reset();
    step(1'b0, 2'd0, 19'h05A5A);
    step(1'b0, 2'd0, 19'h05A5B);

    // Out-of-range channel on the five-channel instance.
    for (int k = 0; k < 5; k++) ij5[k*W +: W] = W'(19'h10000 + k);
    ij5[1*W +: W] = 19'h2AAAA;
    req5 = 1'b1; ch5 = 3'd1;
    repeat (4) @(negedge tck);
    chk("ch5_active", 32'(ij_act5), 32'd1);
    chk("ch5_ch", 32'(act5), 32'd1);
    chk("ch5_dout", 32'(dout5), 32'h2AAAA);
    chk("ch5_err_clear", 32'(err5), 32'd0);
    ch5 = 3'd5;
    repeat (3) begin
      @(negedge tck);
      chk("bad_err", 32'(err5), 32'd1);
      chk("bad_busy", 32'(busy5), 32'd0);
      chk("bad_ch", 32'(act5), 32'd1);
      chk("bad_dout", 32'(dout5), 32'h2AAAA);
    end
    ch5 = 3'd1;
    @(negedge tck);
    chk("err_sticky", 32'(err5), 32'd1);
    ch5 = 3'd3;
    @(negedge tck);
    chk("ch5_hold_busy", 32'(busy5), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("r5_err", 32'(err5), 32'd0);
    chk("r5_busy", 32'(busy5), 32'd0);
    chk("r5_dout", 32'(dout5), 32'd0);
    chk("r5_ch", 32'(act5), 32'd0);
    chk("r5_ij", 32'(ij_act5), 32'd0);
    @(negedge tck);
    rst_n = 1'b1;
    @(negedge tck);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/firebird7_in_gate1_tessent_data_mux_mch.md
FIREBIRD7_IN_GATE1_TESSENT_DATA_MUX_MCH -- requirements
Module: firebird7_in_gate1_tessent_data_mux_mch

Interface
REQ-001 Parameter WIDTH, default 19: data bit width of every channel and of data_out.
REQ-002 Parameter NUM_CH, default 4: number of IJTAG data channels; legal range 2..16.
REQ-003 Parameter HOLD_CYCLES, default 2: break-before-make hold length in clocks; legal range 1..15.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 ijtag_tck  in  1  sole clock; all state updates on its rising edge.
REQ-006 ijtag_reset  in  1  asynchronous, active-low reset.
REQ-007 ijtag_sel_req  in  1  level; 1 requests IJTAG source, 0 requests functional source.
REQ-008 ijtag_sel_ch  in  $clog2(NUM_CH)  requested IJTAG channel; sampled only while ijtag_sel_req=1.
REQ-009 functional_data_in  in  WIDTH  functional source.
REQ-010 ijtag_data_in  in  NUM_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-011 data_out  out  WIDTH  registered mux output.
REQ-012 active_ch  out  $clog2(NUM_CH)  channel currently driving data_out; 0 when functional.
REQ-013 ijtag_active  out  1  1 while state is IJTAG.
REQ-014 switch_busy  out  1  1 while state is HOLD.
REQ-015 sel_err  out  1  sticky: ijtag_sel_ch >= NUM_CH was seen with ijtag_sel_req=1.

Function
REQ-016 The FSM SHALL have exactly three states: FUNC, HOLD, IJTAG.
REQ-017 Target = (FUNC) if ijtag_sel_req=0, else (IJTAG, ijtag_sel_ch); an out-of-range channel SHALL be ignored (target stays current source) and SHALL set sel_err.
REQ-018 In FUNC or IJTAG with target equal to the current source, the state SHALL not change.
REQ-019 In FUNC or IJTAG with target different from the current source, the FSM SHALL enter HOLD, latch the target, and load the hold counter with HOLD_CYCLES-1.
REQ-020 In HOLD, the counter SHALL decrement each cycle; at 0 the FSM SHALL enter the latched target (FUNC or IJTAG with latched channel).
REQ-021 A legal target change during HOLD SHALL re-latch the target and reload the counter (HOLD restarts; total HOLD length always HOLD_CYCLES after the last change).
REQ-022 data_out SHALL equal the selected source sampled on the previous edge (latency 1) in FUNC and IJTAG, and SHALL hold its last value throughout HOLD.
REQ-023 The first data_out update after HOLD SHALL come from the new source, one cycle after the state enters it.
REQ-024 active_ch and ijtag_active SHALL be registered and SHALL change on the same edge that leaves HOLD.
REQ-025 sel_err SHALL clear only on reset.

Reset
REQ-026 Assertion of ijtag_reset SHALL immediately force state FUNC, data_out=0, active_ch=0, ijtag_active=0, switch_busy=0, sel_err=0, counter=0, latched target FUNC, including mid-HOLD.
REQ-027 After deassertion the block SHALL resume per REQ-017..REQ-023 on the first rising edge.

Configuration
REQ-028 With macro FIREBIRD7_TESSENT_DATA_MUX_PARITY_EN defined, the block SHALL add output data_out_par (1 bit), registered, equal to even-parity XOR of the value loaded into data_out, held in HOLD, reset 0.
REQ-029 Without the macro, data_out_par and its logic SHALL not exist; all other behaviour identical.

Structure
REQ-030 The package firebird7_in_gate1_tessent_data_mux_pkg SHALL hold the state enum (FUNC, HOLD, IJTAG) and the default values of WIDTH, NUM_CH, HOLD_CYCLES.
REQ-031 The hold counter SHALL be the sub-module firebird7_in_gate1_tessent_data_mux_hold_ctr (load, decrement, zero flag, async active-low reset).

Verification (WIDTH=19, NUM_CH=4, HOLD_CYCLES=2)
REQ-032 Reset, functional_data_in=19'h1234A -> next edge data_out=19'h1234A, ijtag_active=0, switch_busy=0.
REQ-033 FUNC, sel_req=1, ch=2, ch2 data=19'h7FFFF -> switch_busy=1 for 2 cycles with data_out held at 19'h1234A, then ijtag_active=1, active_ch=2, data_out=19'h7FFFF one cycle later.
REQ-034 HOLD toward ch2, ch changes to 3 after 1 cycle -> HOLD extends 2 cycles from the change, then active_ch=3.
REQ-035 IJTAG ch1, sel_req=1, ch=5 (width-3 override bench) -> sel_err=1, state unchanged, data_out stays from ch1.
REQ-036 Reset asserted mid-HOLD -> all outputs 0 immediately, state FUNC after deassertion.
REQ-037 Parity build, data_out loaded 19'h00007 -> data_out_par=1, held through a subsequent HOLD.
